// File: rtl/sram_ring_master_if.sv
// Wishbone bus between sram_ring_master (initiator) and the SRAM bridge (target).
//   cyc   : cycle active, held until ack is sampled
//   we    : 1 = write, 0 = read
//   adr   : SRAM byte address
//   dat_w : write data, initiator to target
//   dat_r : read data, target to initiator
//   ack   : target acknowledge, a level held while cyc stays high
interface sram_ring_master_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              cyc;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [7:0]        dat_w;
    logic [7:0]        dat_r;
    logic              ack;

    modport master (
        output cyc, we, adr, dat_w,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, we, adr, dat_w,
        output dat_r, ack
    );
endinterface

// File: rtl/sram_ring_master.sv
// Byte-wide ring-buffer FIFO stored in an external single-port SRAM, reached
// through the Wishbone target port of the SRAM bridge. Read and write
// transfers share the bus through an alternating-priority arbiter.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   flush_i           synchronous clear of ring contents
//   wr_valid_i/wr_data_i/wr_ready_o   write byte stream (1-byte holding reg)
//   rd_valid_o/rd_data_o/rd_ready_i   read byte stream (1-byte output reg)
//   level_o           bytes currently held in SRAM
//   overrun_o         one-cycle pulse when an unread byte is overwritten
//   wb                Wishbone initiator (sram_ring_master_if.master)
//
// Build option: define SRAM_RING_OVERWRITE_EN to keep accepting writes when
// the ring is full, dropping the oldest stored byte. Without it writes stall
// at full and overrun_o is tied low.
module sram_ring_master #(
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              wr_valid_i,
    input  logic [7:0]        wr_data_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    output logic [7:0]        rd_data_o,
    input  logic              rd_ready_i,
    output logic [ADDR_W:0]   level_o,
    output logic              overrun_o,
    sram_ring_master_if.master wb
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;
    typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

    state_t            state, state_d;
    grant_t            last_grant, last_grant_d;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_d;
    logic [ADDR_W:0]   level, level_d;
    logic [7:0]        wbuf, wbuf_d;
    logic              wbuf_v, wbuf_v_d;
    logic              rd_valid, rd_valid_d;
    logic [7:0]        rd_data, rd_data_d;
    logic              cyc, cyc_d;
    logic              we, we_d;
    logic [ADDR_W-1:0] adr, adr_d;
    logic [7:0]        dat_w, dat_w_d;
    // Set when a flush lands while a bus cycle is in flight; its result is
    // dropped when the ack arrives.
    logic              discard, discard_d;

    logic full, wr_elig, rd_elig, can_grant, grant_wr, grant_rd;
    logic done, commit, wr_hs, rd_hs;

    assign full  = (level == DEPTH);
    assign wr_hs = wr_valid_i && !wbuf_v;
    assign rd_hs = rd_valid && rd_ready_i;

`ifdef SRAM_RING_OVERWRITE_EN
    logic overrun, overrun_d;
    assign wr_elig = wbuf_v;
`else
    assign wr_elig = wbuf_v && !full;
`endif
    // Only refill the output register when it is empty, so a pop and a refill
    // never coincide.
    assign rd_elig = (level != '0) && !rd_valid;

    // A still-high ack in IDLE is the tail of the previous cycle (or a stale
    // one after reset); wait for it to drop before granting again.
    assign can_grant = (state == IDLE) && !wb.ack && !flush_i;
    assign grant_wr  = can_grant && wr_elig && (!rd_elig || last_grant == GRANT_RD);
    assign grant_rd  = can_grant && rd_elig && (!wr_elig || last_grant == GRANT_WR);
    assign done      = (state != IDLE) && wb.ack;
    assign commit    = done && !discard && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_d = WR;
                end else if (grant_rd) begin
                    state_d = RD;
                end
            end
            WR, RD: begin
                if (wb.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant;
        wr_ptr_d     = wr_ptr;
        rd_ptr_d     = rd_ptr;
        level_d      = level;
        wbuf_d       = wbuf;
        wbuf_v_d     = wbuf_v;
        rd_valid_d   = rd_valid;
        rd_data_d    = rd_data;
        cyc_d        = cyc;
        we_d         = we;
        adr_d        = adr;
        dat_w_d      = dat_w;
        discard_d    = discard;
`ifdef SRAM_RING_OVERWRITE_EN
        overrun_d    = 1'b0;
`endif

        if (wr_hs) begin
            wbuf_d   = wr_data_i;
            wbuf_v_d = 1'b1;
        end
        if (rd_hs) begin
            rd_valid_d = 1'b0;
        end

        if (grant_wr || grant_rd) begin
            cyc_d        = 1'b1;
            we_d         = grant_wr;
            adr_d        = grant_wr ? wr_ptr : rd_ptr;
            dat_w_d      = wbuf;
            last_grant_d = grant_wr ? GRANT_WR : GRANT_RD;
        end

        if (done) begin
            cyc_d     = 1'b0;
            discard_d = 1'b0;
        end

        if (commit) begin
            if (state == WR) begin
                wbuf_v_d = 1'b0;
                wr_ptr_d = wr_ptr + 1'b1;
`ifdef SRAM_RING_OVERWRITE_EN
                // At full wr_ptr == rd_ptr: the write replaced the oldest
                // byte, so the read pointer skips past it.
                if (full) begin
                    rd_ptr_d  = rd_ptr + 1'b1;
                    overrun_d = 1'b1;
                end else begin
                    level_d = level + 1'b1;
                end
`else
                level_d = level + 1'b1;
`endif
            end else begin
                rd_data_d  = wb.dat_r;
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr + 1'b1;
                level_d    = level - 1'b1;
            end
        end

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            wbuf_v_d   = 1'b0;
            rd_valid_d = 1'b0;
            if ((state != IDLE) && !wb.ack) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= GRANT_RD;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            wbuf       <= '0;
            wbuf_v     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            cyc        <= 1'b0;
            we         <= 1'b0;
            adr        <= '0;
            dat_w      <= '0;
            discard    <= 1'b0;
`ifdef SRAM_RING_OVERWRITE_EN
            overrun    <= 1'b0;
`endif
        end else begin
            last_grant <= last_grant_d;
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            level      <= level_d;
            wbuf       <= wbuf_d;
            wbuf_v     <= wbuf_v_d;
            rd_valid   <= rd_valid_d;
            rd_data    <= rd_data_d;
            cyc        <= cyc_d;
            we         <= we_d;
            adr        <= adr_d;
            dat_w      <= dat_w_d;
            discard    <= discard_d;
`ifdef SRAM_RING_OVERWRITE_EN
            overrun    <= overrun_d;
`endif
        end
    end

    assign wr_ready_o = !wbuf_v;
    assign rd_valid_o = rd_valid;
    assign rd_data_o  = rd_data;
    assign level_o    = level;
    assign wb.cyc     = cyc;
    assign wb.we      = we;
    assign wb.adr     = adr;
    assign wb.dat_w   = dat_w;
`ifdef SRAM_RING_OVERWRITE_EN
    assign overrun_o  = overrun;
`else
    assign overrun_o  = 1'b0;
`endif
endmodule
